// File: rtl/sprite_pkg.sv
// sprite_pkg: shared constants and types for the sprite ROM arbiter.
package sprite_pkg;
    localparam int N_REQ_DEF  = 4;
    localparam int REQ_PACMAN = 0;
    localparam int REQ_RED    = 1;
    localparam int REQ_ORANGE = 2;
    localparam int REQ_BLUE   = 3;
    typedef logic [1:0] req_id_t;
endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// rr_pick: rotating priority encoder, first set request at or after i_start wins.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
)(
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_start,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx
);
    int w_j;
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        w_j   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_j = (int'(i_start) + k) % N;
            if (i_req[w_j]) begin
                o_gnt      = '0;
                o_gnt[w_j] = 1'b1;
                o_idx      = IW'(w_j);
            end
        end
    end
endmodule

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: shares one synchronous sprite ROM among N requesters,
// round-robin or fixed priority with starvation guard, returning tagged data.
module sprite_rom_arbiter
    import sprite_pkg::*;
#(
    parameter int N_REQ      = N_REQ_DEF,
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 24,
    parameter int ROM_LAT    = 1,
    parameter int STARVE_MAX = 7
)(
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic                      fixed_pri,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    output logic [N_REQ-1:0]          gnt,
    output logic                      rom_rd,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic                      rd_valid,
    output logic [$clog2(N_REQ)-1:0]  rd_id,
    output logic [DATA_W-1:0]         rd_data
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [IW-1:0]                r_ptr, w_idx, w_start;
    logic [N_REQ-1:0][CW-1:0]     r_cnt;
    logic [N_REQ-1:0]             w_req, w_starved, w_pick;
    logic [ROM_LAT-1:0]           r_vld;
    logic [ROM_LAT-1:0][IW-1:0]   r_id;

    // Masking req during reset keeps the combinational grant quiet while Reset_n is low.
    assign w_req = Reset_n ? req : '0;

    always_comb begin
        w_starved = '0;
        for (int i = 0; i < N_REQ; i++)
            w_starved[i] = w_req[i] && (r_cnt[i] == CW'(STARVE_MAX));
    end

    assign w_pick  = (fixed_pri && |w_starved) ? w_starved : w_req;
    assign w_start = fixed_pri ? '0 : r_ptr;

    rr_pick #(.N(N_REQ)) u_pick (
        .i_req   (w_pick),
        .i_start (w_start),
        .o_gnt   (gnt),
        .o_idx   (w_idx)
    );

    assign rom_rd   = |gnt;
    assign rom_addr = rom_rd ? req_addr[w_idx*ADDR_W +: ADDR_W] : '0;
    assign rd_valid = r_vld[ROM_LAT-1];
    assign rd_id    = r_id[ROM_LAT-1];
    assign rd_data  = rom_data;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_ptr <= '0;
            r_cnt <= '0;
            r_vld <= '0;
            r_id  <= '0;
        end else begin
            if (!fixed_pri && rom_rd)
                r_ptr <= (w_idx == IW'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
            for (int i = 0; i < N_REQ; i++)
                r_cnt[i] <= (gnt[i] || !req[i]) ? '0 :
                            (r_cnt[i] == CW'(STARVE_MAX)) ? r_cnt[i] : r_cnt[i] + 1'b1;
            r_vld[0] <= rom_rd;
            r_id[0]  <= w_idx;
            for (int k = 1; k < ROM_LAT; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_id[k]  <= r_id[k-1];
            end
        end
    end
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter: directed plus random checks of two arbiter instances
// (ROM latency 1 and 3) against a behavioural model of the arbitration rules.
module tb_sprite_rom_arbiter;
    import sprite_pkg::*;
    localparam int STARVE = 7;

    logic        Clk, Reset_n, fixed_pri;
    logic [3:0]  req;
    logic [47:0] req_addr;
    logic [3:0]  gnt1, gnt3;
    logic        rom_rd1, rom_rd3, rd_valid1, rd_valid3;
    logic [11:0] rom_addr1, rom_addr3;
    logic [23:0] rom_data1, rd_data1, rd_data3;
    logic [2:0][23:0] rp3;
    logic [1:0]  rd_id1, rd_id3;

    sprite_rom_arbiter #(.ROM_LAT(1)) u1 (
        .Clk(Clk), .Reset_n(Reset_n), .fixed_pri(fixed_pri), .req(req), .req_addr(req_addr),
        .gnt(gnt1), .rom_rd(rom_rd1), .rom_addr(rom_addr1), .rom_data(rom_data1),
        .rd_valid(rd_valid1), .rd_id(rd_id1), .rd_data(rd_data1));
    sprite_rom_arbiter #(.ROM_LAT(3)) u3 (
        .Clk(Clk), .Reset_n(Reset_n), .fixed_pri(fixed_pri), .req(req), .req_addr(req_addr),
        .gnt(gnt3), .rom_rd(rom_rd3), .rom_addr(rom_addr3), .rom_data(rp3[2]),
        .rd_valid(rd_valid3), .rd_id(rd_id3), .rd_data(rd_data3));

    // ROM model returns its address as data.
    always_ff @(posedge Clk) begin
        rom_data1 <= {12'h0, rom_addr1};
        rp3       <= {rp3[1:0], {12'h0, rom_addr3}};
    end

    initial Clk = 0;
    always #5 Clk = ~Clk;

    int n_cmp = 0, n_err = 0;
    int cyc = 0, first_valid = 0, ptr = 0, win = -1;
    int wait_cnt[4];
    bit hist_v[4096];
    int hist_id[4096];
    logic [11:0] hist_a[4096];

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_pick();
        if (!Reset_n) return -1;
        if (fixed_pri) begin
            for (int i = 0; i < 4; i++) if (req[i] && wait_cnt[i] >= STARVE) return i;
            for (int i = 0; i < 4; i++) if (req[i]) return i;
            return -1;
        end
        for (int k = 0; k < 4; k++) if (req[(ptr + k) % 4]) return (ptr + k) % 4;
        return -1;
    endfunction

    task automatic check_ret(int lat, logic v, logic [1:0] id, logic [23:0] d);
        int s = cyc - lat;
        bit ev = (s >= first_valid) && (s >= 0) && hist_v[s >= 0 ? s : 0];
        chk($sformatf("L%0d_valid@%0d", lat, cyc), v, ev);
        if (ev) begin
            chk($sformatf("L%0d_id@%0d", lat, cyc), id, hist_id[s]);
            chk($sformatf("L%0d_data@%0d", lat, cyc), d, {12'h0, hist_a[s]});
        end
    endtask

    task automatic cycle(int eg = -1);
        logic [11:0] ea;
        @(negedge Clk);
        if (!Reset_n) first_valid = cyc + 1;
        win = model_pick();
        ea  = (win < 0) ? 12'h0 : req_addr[win*12 +: 12];
        chk($sformatf("gnt1@%0d", cyc), gnt1, (win < 0) ? 0 : (1 << win));
        chk($sformatf("gnt3@%0d", cyc), gnt3, (win < 0) ? 0 : (1 << win));
        chk($sformatf("rom_rd@%0d", cyc), rom_rd1, win >= 0);
        chk($sformatf("rom_addr@%0d", cyc), rom_addr1, ea);
        chk($sformatf("rom_addr3@%0d", cyc), rom_addr3, ea);
        if (eg >= 0) chk($sformatf("dir_gnt@%0d", cyc), gnt1, eg);
        hist_v[cyc]  = win >= 0;
        hist_id[cyc] = win;
        hist_a[cyc]  = ea;
        check_ret(1, rd_valid1, rd_id1, rd_data1);
        check_ret(3, rd_valid3, rd_id3, rd_data3);
        @(posedge Clk);
        if (!Reset_n) begin
            ptr = 0;
            for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
        end else begin
            for (int i = 0; i < 4; i++)
                wait_cnt[i] = (i == win || !req[i]) ? 0 : (wait_cnt[i] < STARVE ? wait_cnt[i] + 1 : STARVE);
            if (!fixed_pri && win >= 0) ptr = (win + 1) % 4;
        end
        cyc++;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
        Reset_n = 0; fixed_pri = 0; req = 4'b1111; req_addr = {$urandom, $urandom};
        #2;
        cycle(0); cycle(0);
        Reset_n = 1;
        cycle(1);
        // round-robin rotation with everyone requesting
        for (int k = 0; k < 8; k++) cycle(1 << ((k + 1) % 4));
        req = 0; cycle(); cycle(); cycle();
        // tagged return of a single read
        req = 4'b0100; req_addr[REQ_ORANGE*12 +: 12] = 12'h2A4;
        cycle(4);
        req = 0;
        for (int k = 0; k < 4; k++) cycle(0);
        // fixed priority with starvation guard
        fixed_pri = 1; req = 4'b1001;
        for (int k = 0; k < 7; k++) cycle(1);
        cycle(1 << REQ_BLUE);
        cycle(1);
        req = 0; fixed_pri = 0; cycle();
        // pointer wrap with sparse requests
        req = 4'b0100; cycle(4);
        req = 4'b0101; cycle(1); cycle(4);
        req = 0; cycle();
        // reset while a read is in flight
        req = 4'b0010; cycle(2);
        Reset_n = 0; req = 0; cycle(0); cycle(0);
        Reset_n = 1;
        for (int k = 0; k < 5; k++) cycle(0);
        req = 4'b1111; cycle(1);
        req = 0; cycle();
        // randomized traffic honouring the hold-until-granted handshake
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (req[i] && win == i) begin
                    req[i] = $urandom_range(0, 1);
                    req_addr[i*12 +: 12] = 12'($urandom);
                end else if (!req[i] && $urandom_range(0, 9) < 4) begin
                    req[i] = 1'b1;
                    req_addr[i*12 +: 12] = 12'($urandom);
                end
            end
            if ($urandom_range(0, 19) == 0) fixed_pri = ~fixed_pri;
            Reset_n = ($urandom_range(0, 99) != 0);
            if (!Reset_n) req = 0;
            cycle();
            Reset_n = 1;
        end
        req = 0;
        for (int k = 0; k < 4; k++) cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
